// File: rtl/mem_seq_pkg.sv
// ============================================================================
// mem_seq_pkg
// Shared state encoding, mode encoding and address scaling for the sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ISSUE  = 3'd1;
  localparam state_t ST_WAIT   = 3'd2;
  localparam state_t ST_NEXT   = 3'd3;
  localparam state_t ST_FINISH = 3'd4;
  localparam state_t ST_ERR    = 3'd5;

  localparam logic [1:0] MODE_RD    = 2'b00;
  localparam logic [1:0] MODE_WR    = 2'b01;
  localparam logic [1:0] MODE_WR_RD = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  // One 64-bit beat spans two 32-bit words.
  localparam int BEAT_SHIFT = 1;

  function automatic logic first_is_write(input logic [1:0] m);
    logic r;
    r = 1'b0;
    case (m)
      MODE_WR, MODE_WR_RD: r = 1'b1;
      MODE_RD, MODE_RSVD:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_seq_timeout_cnt.sv
// ============================================================================
// mem_seq_timeout_cnt
// Loadable WAIT-cycle counter; saturates at TIMEOUT_CYCLES-1 and flags expiry.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_seq_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CW             = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          expired_o
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign cnt_o     = cnt_q;
  assign expired_o = (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/mem_access_sequencer.sv
// ============================================================================
// mem_access_sequencer
// Issues a strided sequence of read/write launches and tracks completion.
// Optional perf counters: define MEM_SEQ_PERF_CNT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Abort,
  input  logic [1:0]       Mode,
  input  logic [29:0]      BaseAddr,
  input  logic [7:0]       Stride,
  input  logic [CNT_W-1:0] Count,
  input  logic             RdDone,
  input  logic             WrDone,
  output logic             GoRead,
  output logic             GoWrite,
  output logic [29:0]      source_address,
  output logic [29:0]      destination_address,
  output logic [31:0]      length,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [CNT_W-1:0] Completed
`ifdef MEM_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]      LatencySum,
  output logic [15:0]      LatencyMax
`endif
);

  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       stride_q, stride_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] completed_q, completed_d;
  logic [29:0]      addr_q, addr_d;
  logic             error_q, error_d;
  logic             rd_phase_q, rd_phase_d;

  logic             w_accept;
  logic             w_match;
  logic             w_last;
  logic             w_expired;
  logic [TCW-1:0]   w_wait_cnt;

  assign w_accept = Start && !Abort;
  assign w_match  = rd_phase_q ? RdDone : WrDone;
  assign w_last   = ((idx_q + CNT_W'(1)) == count_q);

  mem_seq_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CW             (TCW)
  ) u_timeout_cnt (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .load_i    (state_q == ST_ISSUE),
    .en_i      (state_q == ST_WAIT),
    .cnt_o     (w_wait_cnt),
    .expired_o (w_expired)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    stride_d    = stride_q;
    count_d     = count_q;
    idx_d       = idx_q;
    completed_d = completed_q;
    addr_d      = addr_q;
    error_d     = error_q;
    rd_phase_d  = rd_phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          mode_d      = Mode;
          stride_d    = Stride;
          count_d     = Count;
          addr_d      = BaseAddr;
          idx_d       = '0;
          completed_d = '0;
          error_d     = 1'b0;
          rd_phase_d  = !first_is_write(Mode);
          state_d     = (Count == '0) ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = Abort ? ST_FINISH : ST_WAIT;
      ST_WAIT: begin
        // A matching done wins over an expiry in the same cycle.
        if (Abort) begin
          state_d = ST_FINISH;
        end else if (w_match) begin
          if (!rd_phase_q && (mode_q == MODE_WR_RD)) begin
            rd_phase_d = 1'b1;
            state_d    = ST_ISSUE;
          end else begin
            state_d = ST_NEXT;
          end
        end else if (w_expired) begin
          error_d = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_NEXT: begin
        if (Abort) begin
          state_d = ST_FINISH;
        end else begin
          completed_d = completed_q + CNT_W'(1);
          idx_d       = idx_q + CNT_W'(1);
          addr_d      = addr_q + (30'(stride_q) << BEAT_SHIFT);
          rd_phase_d  = !first_is_write(mode_q);
          state_d     = w_last ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_FINISH, ST_ERR: state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_RD;
      stride_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      completed_q <= '0;
      addr_q      <= '0;
      error_q     <= 1'b0;
      rd_phase_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      stride_q    <= stride_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      completed_q <= completed_d;
      addr_q      <= addr_d;
      error_q     <= error_d;
      rd_phase_q  <= rd_phase_d;
    end
  end

  assign GoRead              = (state_q == ST_ISSUE) && rd_phase_q;
  assign GoWrite             = (state_q == ST_ISSUE) && !rd_phase_q;
  assign Busy                = (state_q != ST_IDLE);
  assign Done                = (state_q == ST_FINISH) || (state_q == ST_ERR);
  assign Error               = error_q;
  assign Completed           = completed_q;
  assign source_address      = addr_q;
  assign destination_address = addr_q;
  assign length              = 32'(idx_q);

`ifdef MEM_SEQ_PERF_CNT_EN
  logic [31:0] lat_sum_q;
  logic [15:0] lat_max_q;
  logic [31:0] w_wait_dur;

  // The counter is monotonic within one WAIT, so a per-cycle compare tracks the max.
  assign w_wait_dur = 32'(w_wait_cnt) + 32'd1;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      lat_sum_q <= '0;
      lat_max_q <= '0;
    end else if ((state_q == ST_IDLE) && w_accept) begin
      lat_sum_q <= '0;
      lat_max_q <= '0;
    end else if (state_q == ST_WAIT) begin
      if (lat_sum_q != '1) begin
        lat_sum_q <= lat_sum_q + 32'd1;
      end
      if (w_wait_dur > 32'(lat_max_q)) begin
        lat_max_q <= (w_wait_dur > 32'h0000_FFFF) ? 16'hFFFF : w_wait_dur[15:0];
      end
    end
  end

  assign LatencySum = lat_sum_q;
  assign LatencyMax = lat_max_q;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^w_wait_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
// ============================================================================
// tb_mem_access_sequencer
// Randomized self-checking bench with a transaction-level reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_sequencer;

  localparam int TO = 8;
  localparam int CW = 16;

  typedef struct {
    bit          wr;
    logic [29:0] addr;
    logic [31:0] len;
  } go_t;

  logic          Clk = 1'b0;
  logic          Rst, Start, Abort, RdDone, WrDone;
  logic [1:0]    Mode;
  logic [29:0]   BaseAddr;
  logic [7:0]    Stride;
  logic [CW-1:0] Count;
  logic          GoRead, GoWrite, Busy, Done, Error;
  logic [29:0]   source_address, destination_address;
  logic [31:0]   length;
  logic [CW-1:0] Completed;
`ifdef MEM_SEQ_PERF_CNT_EN
  logic [31:0]   LatencySum;
  logic [15:0]   LatencyMax;
`endif

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  mem_access_sequencer #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .Clk                 (Clk),
    .Rst                 (Rst),
    .Start               (Start),
    .Abort               (Abort),
    .Mode                (Mode),
    .BaseAddr            (BaseAddr),
    .Stride              (Stride),
    .Count               (Count),
    .RdDone              (RdDone),
    .WrDone              (WrDone),
    .GoRead              (GoRead),
    .GoWrite             (GoWrite),
    .source_address      (source_address),
    .destination_address (destination_address),
    .length              (length),
    .Busy                (Busy),
    .Done                (Done),
    .Error               (Error),
    .Completed           (Completed)
`ifdef MEM_SEQ_PERF_CNT_EN
    ,
    .LatencySum          (LatencySum),
    .LatencyMax          (LatencyMax)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Word address of access j: base + 2*stride*j, modulo 2^30.
  function automatic logic [29:0] addr_of(input logic [29:0] b, input logic [7:0] s, input int j);
    logic [63:0] a;
    a = 64'(b) + 64'(s) * 64'(2 * j);
    return a[29:0];
  endfunction

  task automatic run_seq(input string nm, input logic [1:0] m, input logic [29:0] b,
                         input logic [7:0] s, input int n, input int dly,
                         input int abort_acc, input bit mute);
    go_t exp_q[$];
    go_t e;
    int  per, keep, exp_comp, go_cnt, t, resp_t, abort_t, exp_done_t, done_t;
    bit  exp_err, wr_first, pend_rd;
    wr_first = (m == 2'b01) || (m == 2'b10);
    per      = (m == 2'b10) ? 2 : 1;
    for (int j = 0; j < n; j++) begin
      if (wr_first)    exp_q.push_back('{1'b1, addr_of(b, s, j), 32'(j)});
      if (m != 2'b01)  exp_q.push_back('{1'b0, addr_of(b, s, j), 32'(j)});
    end
    keep = mute ? 1 : ((abort_acc >= 0) ? abort_acc * per + 1 : exp_q.size());
    while (exp_q.size() > keep) void'(exp_q.pop_back());
    exp_comp   = mute ? 0 : ((abort_acc >= 0) ? abort_acc : n);
    exp_err    = mute;
    exp_done_t = (n == 0) ? 1 : -1;
    go_cnt = 0; resp_t = -1; abort_t = -1; done_t = -1; pend_rd = 1'b0;

    @(negedge Clk);
    Start = 1'b1; Abort = 1'b0; Mode = m; BaseAddr = b; Stride = s; Count = CW'(n);
    t = 0;
    while (done_t < 0 && t < 400) begin
      @(negedge Clk);
      t++;
      Start = 1'b0; Abort = 1'b0; RdDone = 1'b0; WrDone = 1'b0;
      Mode = 2'($urandom); BaseAddr = 30'($urandom); Stride = 8'($urandom); Count = CW'($urandom);
      chk({nm, ".busy"}, 32'(Busy), 32'd1);
      if (t == 1) chk({nm, ".err_clr"}, 32'(Error), 32'd0);
      if (Done) begin
        done_t = t;
      end else begin
        if (GoRead || GoWrite) begin
          if (exp_q.size() == 0) begin
            chk({nm, ".extra_go"}, 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk({nm, ".go_kind"}, {30'd0, GoWrite, GoRead}, e.wr ? 32'd2 : 32'd1);
            chk({nm, ".src"}, 32'(source_address), 32'(e.addr));
            chk({nm, ".dst"}, 32'(destination_address), 32'(e.addr));
            chk({nm, ".len"}, length, e.len);
          end
          pend_rd = GoRead;
          if (abort_acc >= 0 && go_cnt == abort_acc * per) abort_t = t + 2;
          else if (!mute) resp_t = t + 1 + ((dly >= 0) ? dly : int'($urandom_range(0, TO - 1)));
          go_cnt++;
          if (mute) exp_done_t = t + TO + 1;
        end else if (t == abort_t) begin
          Abort = 1'b1;
          exp_done_t = t + 1;
        end else if (t == resp_t) begin
          if (pend_rd) RdDone = 1'b1; else WrDone = 1'b1;
          if (go_cnt == keep) exp_done_t = t + 2;
        end else if (resp_t > t || abort_t > t || mute) begin
          if ($urandom_range(0, 1) == 1) begin
            if (pend_rd) WrDone = 1'b1; else RdDone = 1'b1;
          end
        end
        if ($urandom_range(0, 7) == 0) Start = 1'b1;
      end
    end
    if (done_t < 0) chk({nm, ".done_seen"}, 32'd0, 32'd1);
    chk({nm, ".done_t"}, 32'(done_t), 32'(exp_done_t));
    chk({nm, ".completed"}, 32'(Completed), 32'(exp_comp));
    chk({nm, ".error"}, 32'(Error), 32'(exp_err));
    chk({nm, ".go_left"}, 32'(exp_q.size()), 32'd0);
    Start = 1'b0; Abort = 1'b0; RdDone = 1'b0; WrDone = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk({nm, ".post_done"}, 32'(Done), 32'd0);
      chk({nm, ".post_busy"}, 32'(Busy), 32'd0);
      chk({nm, ".post_go"}, 32'(GoRead | GoWrite), 32'd0);
    end
    chk({nm, ".comp_hold"}, 32'(Completed), 32'(exp_comp));
    chk({nm, ".err_hold"}, 32'(Error), 32'(exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1; Start = 1'b0; Abort = 1'b0; RdDone = 1'b0; WrDone = 1'b0;
    Mode = 2'b00; BaseAddr = '0; Stride = '0; Count = '0;
    repeat (3) @(negedge Clk);
    chk("rst.goread",  32'(GoRead), 32'd0);
    chk("rst.gowrite", 32'(GoWrite), 32'd0);
    chk("rst.busy",    32'(Busy), 32'd0);
    chk("rst.done",    32'(Done), 32'd0);
    chk("rst.error",   32'(Error), 32'd0);
    chk("rst.comp",    32'(Completed), 32'd0);
    chk("rst.src",     32'(source_address), 32'd0);
    chk("rst.dst",     32'(destination_address), 32'd0);
    chk("rst.len",     length, 32'd0);
    Rst = 1'b0;

    run_seq("rd3",     2'b00, 30'h100,      8'd1,   3, 3,      -1, 1'b0);
    run_seq("wrrd1",   2'b10, 30'h40,       8'd3,   1, -1,     -1, 1'b0);
    run_seq("cnt0",    2'b00, 30'h80,       8'd1,   0, -1,     -1, 1'b0);
    run_seq("tmo",     2'b00, 30'h10,       8'd2,   2, -1,     -1, 1'b1);
    run_seq("clr",     2'b01, 30'h1000,     8'h10,  3, -1,     -1, 1'b0);
    run_seq("wrap",    2'b00, 30'h3FFFFFFE, 8'd1,   2, -1,     -1, 1'b0);
    run_seq("abort",   2'b00, 30'h200,      8'd5,   5, 2,       1, 1'b0);
    run_seq("edge",    2'b10, 30'h300,      8'd7,   2, TO - 1, -1, 1'b0);
    run_seq("rsvd",    2'b11, 30'h3FFFFF00, 8'hFF,  3, 0,      -1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      run_seq($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 30'($urandom),
              8'($urandom), int'($urandom_range(1, 6)), -1, -1, 1'b0);
    end

    // Start together with Abort in IDLE is dropped.
    @(negedge Clk);
    Start = 1'b1; Abort = 1'b1; Mode = 2'b00; BaseAddr = 30'h55; Stride = 8'd1; Count = CW'(3);
    @(negedge Clk);
    Start = 1'b0; Abort = 1'b0;
    chk("stab.busy", 32'(Busy), 32'd0);
    chk("stab.go",   32'(GoRead | GoWrite), 32'd0);
    @(negedge Clk);
    chk("stab.busy2", 32'(Busy), 32'd0);

    // Reset mid-sequence: immediate response keeps each access at 3 cycles.
    @(negedge Clk);
    Start = 1'b1; Mode = 2'b00; BaseAddr = 30'h200; Stride = 8'd4; Count = CW'(5); RdDone = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (6) @(negedge Clk);
    chk("rstmid.comp", 32'(Completed), 32'd2);
    chk("rstmid.src",  32'(source_address), 32'h210);
    #2 Rst = 1'b1;
    #1;
    chk("rstmid.busy", 32'(Busy), 32'd0);
    chk("rstmid.go",   32'(GoRead | GoWrite), 32'd0);
    chk("rstmid.comp0", 32'(Completed), 32'd0);
    chk("rstmid.addr0", 32'(source_address), 32'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0; RdDone = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      chk("rstmid.nodone", 32'(Done), 32'd0);
      chk("rstmid.idle",   32'(Busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
